// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with a combinational hit path and a word-serial line refill.
// Optional critical-word forwarding during refill is enabled by defining ICACHE_FWD_EN.
module inst_cache #(
    parameter int INDEX_BITS = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc_to_ic,
    output logic        inst_get_ready,
    output logic [31:0] inst_from_ic,
    output logic        mc_req_valid,
    output logic [31:0] mc_req_addr,
    input  logic        mc_resp_valid,
    input  logic [31:0] mc_resp_data
);

    localparam int WB    = $clog2(LINE_WORDS);
    localparam int CW    = (WB > 0) ? WB : 1;
    localparam int TW    = 30 - INDEX_BITS - WB;
    localparam int LINES = 1 << INDEX_BITS;
    localparam logic [CW-1:0] LAST_CNT = CW'(LINE_WORDS - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [INDEX_BITS-1:0]   miss_idx_q, miss_idx_d;
    logic [TW-1:0]           miss_tag_q, miss_tag_d;
    logic                    req_valid_q, req_valid_d;
    logic [31:0]             req_addr_q, req_addr_d;

    logic [TW-1:0]           tag_mem  [LINES];
    logic [31:0]             data_mem [LINES][LINE_WORDS];

    logic [CW-1:0]           pc_word;
    logic [INDEX_BITS-1:0]   pc_idx;
    logic [TW-1:0]           pc_tag;
    logic                    hit_idle;
    logic                    fwd_hit;
    logic                    data_we;
    logic                    tag_we;
    logic [1:0]              unused_pc_lsb;

    assign unused_pc_lsb = pc_to_ic[1:0];

    generate
        if (WB > 0) begin : g_word
            assign pc_word = pc_to_ic[WB+1:2];
        end else begin : g_no_word
            assign pc_word = '0;
        end
    endgenerate

    assign pc_idx = pc_to_ic[INDEX_BITS+WB+1:WB+2];
    assign pc_tag = pc_to_ic[31:INDEX_BITS+WB+2];

    function automatic logic [31:0] make_addr(input logic [TW-1:0] t,
                                              input logic [INDEX_BITS-1:0] i,
                                              input logic [CW-1:0] c);
        logic [31:0] a;
        a = (32'(t) << (INDEX_BITS + WB + 2)) | (32'(i) << (WB + 2));
        if (WB > 0) a = a | (32'(c) << 2);
        return a;
    endfunction

    assign hit_idle = (state_q == IDLE) && valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);

`ifdef ICACHE_FWD_EN
    // The word arriving right now is the one the fetch stage is asking for.
    assign fwd_hit = (state_q == REFILL) && mc_resp_valid && rdy &&
                     (pc_idx == miss_idx_q) && (pc_tag == miss_tag_q) && (pc_word == cnt_q);
`else
    assign fwd_hit = 1'b0;
`endif

    assign inst_get_ready = hit_idle || fwd_hit;
    assign inst_from_ic   = !inst_get_ready ? 32'h0 :
                            fwd_hit         ? mc_resp_data : data_mem[pc_idx][pc_word];
    assign mc_req_valid   = req_valid_q;
    assign mc_req_addr    = req_addr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        miss_idx_d  = miss_idx_q;
        miss_tag_d  = miss_tag_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        data_we     = 1'b0;
        tag_we      = 1'b0;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (!hit_idle) begin
                        state_d         = REFILL;
                        miss_idx_d      = pc_idx;
                        miss_tag_d      = pc_tag;
                        valid_d[pc_idx] = 1'b0;
                        cnt_d           = '0;
                        req_valid_d     = 1'b1;
                        req_addr_d      = make_addr(pc_tag, pc_idx, '0);
                    end
                end
                REFILL: begin
                    if (mc_resp_valid) begin
                        data_we = 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            // Line becomes visible only once every word is in.
                            valid_d[miss_idx_q] = 1'b1;
                            tag_we              = 1'b1;
                            state_d             = IDLE;
                            req_valid_d         = 1'b0;
                            cnt_d               = '0;
                        end else begin
                            cnt_d      = CW'(cnt_q + 1'b1);
                            req_addr_d = make_addr(miss_tag_q, miss_idx_q, CW'(cnt_q + 1'b1));
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            valid_q     <= '0;
            miss_idx_q  <= '0;
            miss_tag_q  <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            miss_idx_q  <= miss_idx_d;
            miss_tag_q  <= miss_tag_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_mem[miss_idx_q][cnt_q] <= mc_resp_data;
        if (tag_we)  tag_mem[miss_idx_q]         <= miss_tag_q;
    end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: refill sequencing, hits, conflicts, redirect, stall and reset.
module tb_inst_cache;

`ifdef ICACHE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] pc_to_ic;
    logic        inst_get_ready;
    logic [31:0] inst_from_ic;
    logic        mc_req_valid;
    logic [31:0] mc_req_addr;
    logic        mc_resp_valid;
    logic [31:0] mc_resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    inst_cache dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .pc_to_ic       (pc_to_ic),
        .inst_get_ready (inst_get_ready),
        .inst_from_ic   (inst_from_ic),
        .mc_req_valid   (mc_req_valid),
        .mc_req_addr    (mc_req_addr),
        .mc_resp_valid  (mc_resp_valid),
        .mc_resp_data   (mc_resp_data)
    );

    always #5 clk = ~clk;

    // Memory contents: line 0 holds 0x11..0x44, everything else is tagged with its address.
    function automatic logic [31:0] data_for(input logic [31:0] a);
        if (a < 32'h10) return ((a >> 2) + 32'd1) * 32'h11;
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Answers requested words first..last of the line at base, one per cycle.
    task automatic serve(input logic [31:0] base, input int first, input int last);
        logic [31:0] a;
        logic        exp_fwd;
        for (int i = first; i <= last; i++) begin
            a = base + 32'(4 * i);
            chk("req_valid", 32'(mc_req_valid), 32'd1);
            chk("req_addr", mc_req_addr, a);
            mc_resp_valid = 1'b1;
            mc_resp_data  = data_for(a);
            #1;
            exp_fwd = FWD && ((pc_to_ic & 32'hFFFF_FFF0) == base) && (pc_to_ic[3:2] == 2'(i));
            chk("refill_ready", 32'(inst_get_ready), 32'(exp_fwd));
            chk("refill_data", inst_from_ic, exp_fwd ? data_for(a) : 32'h0);
            tick();
            mc_resp_valid = 1'b0;
            mc_resp_data  = 32'h0;
        end
    endtask

    task automatic expect_hit(input logic [31:0] pc, input logic [31:0] exp);
        pc_to_ic = pc;
        #1;
        chk("hit_ready", 32'(inst_get_ready), 32'd1);
        chk("hit_data", inst_from_ic, exp);
    endtask

    task automatic expect_miss(input logic [31:0] pc);
        pc_to_ic = pc;
        #1;
        chk("miss_ready", 32'(inst_get_ready), 32'd0);
        chk("miss_data", inst_from_ic, 32'h0);
    endtask

    initial begin
        rst           = 1'b0;
        rdy           = 1'b1;
        pc_to_ic      = 32'h0;
        mc_resp_valid = 1'b0;
        mc_resp_data  = 32'h0;

        // Reset state
        repeat (2) tick();
        chk("rst_req_valid", 32'(mc_req_valid), 32'd0);
        chk("rst_req_addr", mc_req_addr, 32'h0);
        chk("rst_ready", 32'(inst_get_ready), 32'd0);
        rst = 1'b1;

        // Test 1: cold miss on line 0, then hits
        tick();
        serve(32'h0, 0, 3);
        chk("t1_req_dropped", 32'(mc_req_valid), 32'd0);
        expect_hit(32'h0, 32'h11);
        expect_hit(32'h8, 32'h33);
        tick();
        chk("t1_no_req", 32'(mc_req_valid), 32'd0);
        expect_hit(32'h4, 32'h22);
        expect_hit(32'hC, 32'h44);

        // Test 2: conflict on index 0
        expect_miss(32'h400);
        tick();
        serve(32'h400, 0, 3);
        expect_hit(32'h408, 32'hC0DE0408);
        expect_miss(32'h0);
        tick();
        serve(32'h0, 0, 3);
        expect_hit(32'h0, 32'h11);

        // Test 3: redirect to 0x200 while 0x100 refills
        expect_miss(32'h100);
        tick();
        pc_to_ic = 32'h200;
        serve(32'h100, 0, 3);
        expect_miss(32'h200);
        chk("t3_req_gap", 32'(mc_req_valid), 32'd0);
        tick();
        serve(32'h200, 0, 3);
        expect_hit(32'h100, 32'hC0DE0100);
        expect_hit(32'h20C, 32'hC0DE020C);

        // Test 4: evict 0x100 via 0x500, refill 0x100 with a rdy stall at 0x104
        expect_miss(32'h500);
        tick();
        serve(32'h500, 0, 3);
        expect_hit(32'h50C, 32'hC0DE050C);
        expect_miss(32'h100);
        tick();
        serve(32'h100, 0, 0);
        rdy           = 1'b0;
        mc_resp_valid = 1'b1;
        mc_resp_data  = 32'hDEAD_BEEF;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("t4_stall_valid", 32'(mc_req_valid), 32'd1);
            chk("t4_stall_addr", mc_req_addr, 32'h104);
            chk("t4_stall_ready", 32'(inst_get_ready), 32'd0);
        end
        rdy           = 1'b1;
        mc_resp_valid = 1'b0;
        mc_resp_data  = 32'h0;
        serve(32'h100, 1, 3);
        expect_hit(32'h104, 32'hC0DE0104);
        expect_miss(32'h500);

        // Test 5: reset in the middle of a refill, then forwarding check on pc=0x8
        expect_miss(32'h600);
        tick();
        serve(32'h600, 0, 1);
        rst = 1'b0;
        #1;
        chk("t5_rst_req_valid", 32'(mc_req_valid), 32'd0);
        chk("t5_rst_req_addr", mc_req_addr, 32'h0);
        chk("t5_rst_ready", 32'(inst_get_ready), 32'd0);
        pc_to_ic = 32'h100;
        #1;
        chk("t5_rst_all_invalid", 32'(inst_get_ready), 32'd0);
        tick();
        rst = 1'b1;
        expect_miss(32'h0);
        tick();
        chk("t5_refill_addr", mc_req_addr, 32'h0);
        pc_to_ic = 32'h8;
        serve(32'h0, 0, 3);
        expect_hit(32'h8, 32'h33);
        expect_miss(32'h600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
